// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
package mult_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_NUM_REQ = 4;

  function automatic int grant_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and multiplier bus of mult_arbiter; rsp_err exists only with MULT_ARB_TIMEOUT_EN.
interface mult_arbiter_if import mult_arb_pkg::*; #(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]       rsp_product;
`ifdef MULT_ARB_TIMEOUT_EN
  logic                     rsp_err;
`endif
  logic                     mult_start;
  logic [WIDTH-1:0]         mult_multiplicand;
  logic [WIDTH-1:0]         mult_multiplier;
  logic [2*WIDTH-1:0]       mult_product;
  logic                     mult_busy;

  // slave is the arbiter side, master is the requesters plus the multiplier
  modport slave (
    input  req_valid, req_a, req_b, mult_product, mult_busy,
    output req_ready, rsp_valid, rsp_product, mult_start,
           mult_multiplicand, mult_multiplier
`ifdef MULT_ARB_TIMEOUT_EN
    , output rsp_err
`endif
  );

  modport master (
    output req_valid, req_a, req_b, mult_product, mult_busy,
    input  req_ready, rsp_valid, rsp_product, mult_start,
           mult_multiplicand, mult_multiplier
`ifdef MULT_ARB_TIMEOUT_EN
    , input rsp_err
`endif
  );

endinterface

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid requester above last_grant, wrapping.
module rr_picker import mult_arb_pkg::*; #(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int GW      = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [GW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      grant_idx,
  output logic               found
);

  int          pos;
  logic [GW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      pos = (int'(last_grant) + off) % NUM_REQ;
      idx = GW'(pos);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one start/busy multiplier among NUM_REQ requesters.
// Optional watchdog (TIMEOUT parameter, rsp_err) enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter import mult_arb_pkg::*; #(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
`ifdef MULT_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic             clock,
  input  logic             reset,
  mult_arbiter_if.slave    bus,
  output logic             active
);

  localparam int GW = grant_w(NUM_REQ);

  state_t               state;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        grant_idx;
  logic [GW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   pick;
  logic                 pick_found;
  logic [NUM_REQ-1:0]   ready;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic [2*WIDTH-1:0]   rsp_product_r;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 start_r;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid      (bus.req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .grant_idx  (pick_idx),
    .found      (pick_found)
  );

  // Grants are withheld while the multiplier is busy: it has no reset of its own.
  assign ready = (state == IDLE && !bus.mult_busy && !reset && pick_found) ? pick : '0;

  assign bus.req_ready         = ready;
  assign bus.rsp_valid         = rsp_valid_r;
  assign bus.rsp_product       = rsp_product_r;
  assign bus.mult_start        = start_r;
  assign bus.mult_multiplicand = op_a;
  assign bus.mult_multiplier   = op_b;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          rsp_err_r;
  logic          timeout_hit;
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
  assign bus.rsp_err = rsp_err_r;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= GW'(NUM_REQ - 1);
      grant_idx     <= '0;
      op_a          <= '0;
      op_b          <= '0;
      rsp_product_r <= '0;
      rsp_valid_r   <= '0;
      start_r       <= 1'b0;
      active        <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      rsp_err_r     <= 1'b0;
`endif
    end else begin
      start_r     <= 1'b0;
      rsp_valid_r <= '0;
      case (state)
        IDLE: begin
          if (|(ready & bus.req_valid)) begin
            op_a      <= bus.req_a[pick_idx*WIDTH +: WIDTH];
            op_b      <= bus.req_b[pick_idx*WIDTH +: WIDTH];
            grant_idx <= pick_idx;
            start_r   <= 1'b1;
            active    <= 1'b1;
            state     <= START;
          end
        end
        START: begin
`ifdef MULT_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
`ifdef MULT_ARB_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
          if (timeout_hit) begin
            rsp_product_r <= '0;
            rsp_err_r     <= 1'b1;
            rsp_valid_r   <= NUM_REQ'(1) << grant_idx;
            last_grant    <= grant_idx;
            state         <= RESP;
          end else if (bus.mult_busy) begin
            state <= WAIT_DONE;
          end
`else
          if (bus.mult_busy) state <= WAIT_DONE;
`endif
        end
        WAIT_DONE: begin
          if (!bus.mult_busy) begin
            rsp_product_r <= bus.mult_product;
            rsp_valid_r   <= NUM_REQ'(1) << grant_idx;
            last_grant    <= grant_idx;
            state         <= RESP;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            rsp_product_r <= '0;
            rsp_err_r     <= 1'b1;
            rsp_valid_r   <= NUM_REQ'(1) << grant_idx;
            last_grant    <= grant_idx;
            state         <= RESP;
          end
          wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        RESP: begin
`ifdef MULT_ARB_TIMEOUT_EN
          rsp_err_r <= 1'b0;
`endif
          active <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
